mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated in the EX stage of the `mips` pipelined core.
- Executes MULT, MULTU, DIV, DIVU and supports MTHI/MTLO writes.
- Exposes HI/LO for MFHI/MFLO.
- Exposes `busy` so the hazard logic stalls any HI/LO-touching instruction in ID while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  launch the operation selected by `op`; sampled on rising edge
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  32  rs operand (multiplicand / dividend)
- src_b  input  32  rt operand (multiplier / divisor)
- hilo_we  input  1  MTHI/MTLO write enable
- hilo_sel  input  1  0 writes LO, 1 writes HI
- wdata  input  32  MTHI/MTLO data
- cancel  input  1  exception flush; aborts the in-flight operation
- busy  output  1  operation in flight (registered)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous, active-high.
- Reset values: busy=0, hi=0, lo=0, internal counter=0, pending result=0.
- State is IDLE (counter==0) or RUN (counter!=0). busy = (counter!=0), driven from a register with no combinational path from inputs.
- Launch: at an edge with start=1, busy=0, cancel=0:
  - capture the full 64-bit result into pending registers;
  - load counter with MUL_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1);
  - busy is high for exactly N cycles after that edge.
- RUN: counter decrements by 1 each edge.
- Commit: on the edge where the counter goes 1->0, hi/lo take the pending values. New values are visible in the first cycle with busy=0. Back-to-back start in that cycle is legal.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - MULTU: the same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): lo = 0x80000000, hi = 0.
  - Divisor 0 (DIV or DIVU): the op still runs N busy cycles; hi/lo are left unchanged at commit.
- Boundary conditions:
  - start while busy=1: ignored, no effect on the counter or pending result. The core never issues this, since it stalls on start|busy.
  - hilo_we while busy=1: ignored.
  - hilo_we with busy=0 and start=0: the selected register takes wdata at the edge, visible next cycle.
  - start and hilo_we together while idle: start wins, the write is dropped.
  - hilo_we in the cycle the counter goes 1->0: the commit wins, the write is dropped.
  - cancel=1: counter cleared to 0 at the edge and hi/lo unchanged (no commit), including in the final busy cycle. cancel also suppresses a same-edge start and hilo_we.
  - reset mid-operation: immediate return to the reset state, asynchronously, with no commit.
- Stall contract: the core stalls an ID-stage mult/div/mf/mt instruction when (start | busy). That combination lives in the hazard unit, not in this block.

Test Plan:
- Reset mid-run: reset pulse during RUN -> busy, hi and lo all 0 immediately; no later commit.
- MULT timing: MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV signs:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
  - DIVU 7/2 -> lo=3, hi=1.
  - DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11111111, lo=0x22222222 via MTHI/MTLO; then DIVU x/0 -> busy 10 cycles; hi/lo unchanged afterwards.
- Hazards:
  - start and hilo_we asserted during RUN -> ignored; the original result commits.
  - cancel at busy cycle 3 of MULT -> busy drops next cycle; hi/lo unchanged.
  - start in the first idle cycle after a commit -> accepted; busy is high again next cycle.

Source files
------------

// File: rtl/mult_div_if.sv
// Handshake and result signals between the EX-stage control and the multiply/divide unit.
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] wdata;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_we, hilo_sel, wdata, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_we, hilo_sel, wdata, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// The result is computed at launch and held pending; the busy window only models latency.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic       clk,
    input logic       reset,
    mult_div_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_n;
    logic [3:0]  count, count_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;
    logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic        pend_skip, pend_skip_n;

    logic [63:0] prod_s, prod_u;
    logic        div_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe, b_safe;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic [31:0] res_hi, res_lo;

    assign prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
                    $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign prod_u = {32'b0, bus.src_a} * {32'b0, bus.src_b};

    // Signed divide goes through magnitudes so 0x80000000 / -1 needs no overflow special case.
    assign div_zero   = (bus.src_b == 32'd0);
    assign mag_a      = bus.src_a[31] ? -bus.src_a : bus.src_a;
    assign mag_b      = bus.src_b[31] ? -bus.src_b : bus.src_b;
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign b_safe     = div_zero ? 32'd1 : bus.src_b;
    assign quo_mag    = mag_a / mag_b_safe;
    assign rem_mag    = mag_a % mag_b_safe;
    assign quo_s      = (bus.src_a[31] ^ bus.src_b[31]) ? -quo_mag : quo_mag;
    assign rem_s      = bus.src_a[31] ? -rem_mag : rem_mag;
    assign quo_u      = bus.src_a / b_safe;
    assign rem_u      = bus.src_a % b_safe;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (bus.op)
            2'b00:   begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            2'b01:   begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            2'b10:   begin res_hi = rem_s;         res_lo = quo_s;        end
            default: begin res_hi = rem_u;         res_lo = quo_u;        end
        endcase
    end

    always_comb begin
        count_n     = count;
        hi_n        = hi_q;
        lo_n        = lo_q;
        pend_hi_n   = pend_hi;
        pend_lo_n   = pend_lo;
        pend_skip_n = pend_skip;
        if (bus.cancel) begin
            count_n = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    count_n = count - 4'd1;
                    if (count == 4'd1 && !pend_skip) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end
                default: begin
                    if (bus.start) begin
                        count_n     = bus.op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                        pend_hi_n   = res_hi;
                        pend_lo_n   = res_lo;
                        pend_skip_n = bus.op[1] & div_zero;
                    end else if (bus.hilo_we) begin
                        if (bus.hilo_sel) hi_n = bus.wdata;
                        else              lo_n = bus.wdata;
                    end
                end
            endcase
        end
        state_n = (count_n != 4'd0) ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            hi_q      <= hi_n;
            lo_q      <= lo_n;
            pend_hi   <= pend_hi_n;
            pend_lo   <= pend_lo_n;
            pend_skip <= pend_skip_n;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a 64-bit integer arithmetic model of HI/LO.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_if bus();
    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cycles(input logic [1:0] op);
        return op[1] ? 10 : 5;
    endfunction

    // Reference: plain 64-bit integer arithmetic; divide by zero leaves HI/LO alone.
    function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] h, inout logic [31:0] l);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          ps;
        longint unsigned pu;
        case (op)
            2'b00: begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
            2'b01: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
            2'b10: if (b != 0) begin ps = sa / sb; l = ps[31:0]; ps = sa % sb; h = ps[31:0]; end
            default: if (b != 0) begin pu = ua / ub; l = pu[31:0]; pu = ua % ub; h = pu[31:0]; end
        endcase
    endfunction

    // kind: 0 none, 1 start+hilo_we mid-run, 2 cancel, 3 hilo_we only
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input int kind, output int n);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        tick();
        bus.start = 1'b0; bus.hilo_we = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (n == inj_at) begin
                if (kind == 1) begin
                    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = $urandom; bus.src_b = 32'd3;
                    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'hDEADBEEF;
                end else if (kind == 2) begin
                    bus.cancel = 1'b1;
                end else if (kind == 3) begin
                    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.wdata = 32'hCAFEF00D;
                end
            end
            tick();
            bus.start = 1'b0; bus.hilo_we = 1'b0; bus.cancel = 1'b0;
        end
    endtask

    task automatic mt(input logic sel, input logic [31:0] data);
        bus.hilo_we = 1'b1; bus.hilo_sel = sel; bus.wdata = data;
        tick();
        bus.hilo_we = 1'b0;
        if (sel) m_hi = data; else m_lo = data;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    endtask

    task automatic test_directed(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] want_hi, input logic [31:0] want_lo);
        int n;
        run_op(op, a, b, 0, 0, n);
        model_op(op, a, b, m_hi, m_lo);
        n_checks++; if (n !== exp_cycles(op)) begin n_fail++; $display("FAIL %s_cycles got %0d want %0d", name, n, exp_cycles(op)); end
        n_checks++; if (bus.hi !== want_hi) begin n_fail++; $display("FAIL %s_hi got %h want %h", name, bus.hi, want_hi); end
        n_checks++; if (bus.lo !== want_lo) begin n_fail++; $display("FAIL %s_lo got %h want %h", name, bus.lo, want_lo); end
        n_checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL %s_model got %h:%h want %h:%h", name, bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_div_zero();
        int n;
        mt(1'b1, 32'h11111111);
        mt(1'b0, 32'h22222222);
        n_checks++; if (bus.hi !== 32'h11111111 || bus.lo !== 32'h22222222) begin n_fail++; $display("FAIL mt_preload got %h:%h want 11111111:22222222", bus.hi, bus.lo); end
        run_op(2'b11, 32'd12345, 32'd0, 0, 0, n);
        n_checks++; if (n !== 10) begin n_fail++; $display("FAIL divz_cycles got %0d want 10", n); end
        n_checks++; if (bus.hi !== 32'h11111111 || bus.lo !== 32'h22222222) begin n_fail++; $display("FAIL divz_hilo got %h:%h want 11111111:22222222", bus.hi, bus.lo); end
        run_op(2'b10, 32'hFFFF0000, 32'd0, 0, 0, n);
        n_checks++; if (n !== 10 || bus.hi !== 32'h11111111 || bus.lo !== 32'h22222222) begin n_fail++; $display("FAIL divz_signed got %0d %h:%h want 10 11111111:22222222", n, bus.hi, bus.lo); end
    endtask

    task automatic test_hazards();
        int n;
        logic [31:0] h0, l0;
        run_op(2'b00, 32'd1234, 32'd5678, 2, 1, n);
        model_op(2'b00, 32'd1234, 32'd5678, m_hi, m_lo);
        n_checks++; if (n !== 5 || bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL run_ignore got %0d %h:%h want 5 %h:%h", n, bus.hi, bus.lo, m_hi, m_lo); end
        h0 = m_hi; l0 = m_lo;
        run_op(2'b00, 32'h7, 32'h9, 3, 2, n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL cancel_cycles got %0d want 3", n); end
        n_checks++; if (bus.hi !== h0 || bus.lo !== l0) begin n_fail++; $display("FAIL cancel_hilo got %h:%h want %h:%h", bus.hi, bus.lo, h0, l0); end
        run_op(2'b11, 32'd100, 32'd7, 10, 2, n);
        n_checks++; if (n !== 10 || bus.hi !== h0 || bus.lo !== l0) begin n_fail++; $display("FAIL cancel_last got %0d %h:%h want 10 %h:%h", n, bus.hi, bus.lo, h0, l0); end
        run_op(2'b01, 32'd50, 32'd60, 5, 3, n);
        model_op(2'b01, 32'd50, 32'd60, m_hi, m_lo);
        n_checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL commit_vs_we got %h:%h want %h:%h", bus.hi, bus.lo, m_hi, m_lo); end
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.wdata = 32'h5A5A5A5A;
        run_op(2'b01, 32'd3, 32'd4, 0, 0, n);
        model_op(2'b01, 32'd3, 32'd4, m_hi, m_lo);
        n_checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL start_vs_we got %h:%h want %h:%h", bus.hi, bus.lo, m_hi, m_lo); end
        bus.cancel = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
        bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.wdata = 32'h0BAD0BAD;
        tick();
        bus.cancel = 1'b0; bus.start = 1'b0; bus.hilo_we = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL cancel_idle got %0b %h:%h want 0 %h:%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(2'b00, 32'hFFFFFFF0, 32'd16, 0, 0, n);
        model_op(2'b00, 32'hFFFFFFF0, 32'd16, m_hi, m_lo);
        bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'hFFFFFFF9;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %0b want 1", bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin n++; tick(); end
        model_op(2'b10, 32'd1000, 32'hFFFFFFF9, m_hi, m_lo);
        n_checks++; if (n !== 10 || bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL b2b_result got %0d %h:%h want 10 %h:%h", n, bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_midrun();
        int n;
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'hABCDEF01; bus.src_b = 32'h12345;
        tick();
        bus.start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL midrun_reset got %0b %h:%h want 0 0:0", bus.busy, bus.hi, bus.lo); end
        tick();
        reset = 1'b0;
        for (n = 0; n < 8; n++) tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL midrun_nocommit got %0b %h:%h want 0 0:0", bus.busy, bus.hi, bus.lo); end
    endtask

    task automatic test_random();
        int n;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mt(1'($urandom_range(0, 1)), $urandom);
                n_checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin n_fail++; $display("FAIL rand_mt[%0d] got %h:%h want %h:%h", i, bus.hi, bus.lo, m_hi, m_lo); end
            end
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(op, a, b, 0, 0, n);
            model_op(op, a, b, m_hi, m_lo);
            n_checks++; if (n !== exp_cycles(op) || bus.hi !== m_hi || bus.lo !== m_lo) begin
                n_fail++;
                $display("FAIL rand_op[%0d] op=%0d a=%h b=%h got %0d %h:%h want %0d %h:%h", i, op, a, b, n, bus.hi, bus.lo, exp_cycles(op), m_hi, m_lo);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.wdata = 32'd0; bus.cancel = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_reset_midrun();
        test_directed("mult",  2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        test_directed("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        test_directed("div",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        test_directed("divu",  2'b11, 32'd7,        32'd2,        32'd1,        32'd3);
        test_directed("divov", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        test_div_zero();
        test_hazards();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
